// File: rtl/add_substractor.sv
// 8-bit ripple-carry add/subtract unit with registered result and flags.
// One-cycle latency, one operation per cycle, no back-pressure.
module add_substractor (
  input  logic       clk,
  input  logic       reset,
  input  logic       sub,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       in_valid,
  output logic [8:0] out,
  output logic       out_valid,
  output logic       ovf,
  output logic       zero,
  output logic       neg
);

  logic [7:0] bx;
  logic [7:0] s;
  logic [8:0] c;
  logic       ovf_c;

  assign bx   = B ^ {8{sub}};
  assign c[0] = sub;

  // Full-adder cells chained through c[].
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = A[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end

  // Operands of effectively equal sign whose sum flips sign.
  assign ovf_c = (A[7] == bx[7]) && (s[7] != A[7]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= 9'h000;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        // Bit 8 is carry for add, borrow for subtract.
        out  <= {c[8] ^ sub, s};
        ovf  <= ovf_c;
        zero <= (s == 8'h00);
        neg  <= s[7];
      end
    end
  end

endmodule

// File: tb/tb_add_substractor.sv
// Self-checking bench for add_substractor.
// Random and directed stimulus against an arithmetic reference model.
module tb_add_substractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       sub;
  logic [7:0] A;
  logic [7:0] B;
  logic       in_valid;
  logic [8:0] out;
  logic       out_valid;
  logic       ovf;
  logic       zero;
  logic       neg;

  int checks = 0;
  int errors = 0;

  // {out_valid, ovf, zero, neg, out}
  logic [12:0] exp_v;
  logic [12:0] got_v;

  add_substractor dut (
    .clk(clk),
    .reset(reset),
    .sub(sub),
    .A(A),
    .B(B),
    .in_valid(in_valid),
    .out(out),
    .out_valid(out_valid),
    .ovf(ovf),
    .zero(zero),
    .neg(neg)
  );

  always #5 clk = ~clk;

  assign got_v = {out_valid, ovf, zero, neg, out};

  function automatic logic [12:0] model(
    input logic       v,
    input logic       s,
    input logic [7:0] a,
    input logic [7:0] b
  );
    int u;
    int t;
    logic [8:0] r;
    logic o;
    u = s ? int'(a) - int'(b) : int'(a) + int'(b);
    r = u[8:0];
    t = s ? int'($signed(a)) - int'($signed(b))
          : int'($signed(a)) + int'($signed(b));
    o = (t > 127) || (t < -128);
    return {v, o, (r[7:0] == 8'h00), r[7], r};
  endfunction

  task automatic drive(
    input logic       v,
    input logic       s,
    input logic [7:0] a,
    input logic [7:0] b
  );
    @(negedge clk);
    in_valid = v;
    sub = s;
    A = a;
    B = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    sub = 1'b0;
    A = 8'h00;
    B = 8'h00;
    #1;
    checks++;
    if (got_v !== 13'h0) begin
      errors++;
      $display("FAIL reset_async got %h exp %h", got_v, 13'h0);
    end
    tick();
    checks++;
    if (got_v !== 13'h0) begin
      errors++;
      $display("FAIL reset_held got %h exp %h", got_v, 13'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 9'h000};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_first_op got %h exp %h", got_v, exp_v);
    end
  endtask

  task automatic test_directed();
    logic [12:0] tbl [8];
    logic [16:0] op [8];
    op[0] = {1'b0, 8'h01, 8'h02};
    op[1] = {1'b1, 8'h02, 8'h01};
    op[2] = {1'b0, 8'hFF, 8'h01};
    op[3] = {1'b0, 8'h7F, 8'h01};
    op[4] = {1'b1, 8'h01, 8'h02};
    op[5] = {1'b1, 8'h80, 8'h01};
    op[6] = {1'b0, 8'hFF, 8'hFF};
    op[7] = {1'b1, 8'h00, 8'h00};
    tbl[0] = {4'b1000, 9'h003};
    tbl[1] = {4'b1000, 9'h001};
    tbl[2] = {4'b1010, 9'h100};
    tbl[3] = {4'b1101, 9'h080};
    tbl[4] = {4'b1001, 9'h1FF};
    tbl[5] = {4'b1100, 9'h07F};
    tbl[6] = {4'b1001, 9'h1FE};
    tbl[7] = {4'b1010, 9'h000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, op[i][16], op[i][15:8], op[i][7:0]);
      tick();
      checks++;
      if (got_v !== tbl[i]) begin
        errors++;
        $display("FAIL directed_%0d got %h exp %h", i, got_v, tbl[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 8'h12, 8'h34);
    tick();
    exp_v = {4'b1000, 9'h046};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL hold_load got %h exp %h", got_v, exp_v);
    end
    exp_v[12] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
      tick();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL hold_idle_%0d got %h exp %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] held;
    logic        v;
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    held = got_v;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(9, 0) < 7);
      s = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      drive(v, s, a, b);
      tick();
      if (v) held = model(1'b1, s, a, b);
      exp_v = {v, held[11:0]};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_%0d s=%b a=%h b=%h got %h exp %h",
                 i, s, a, b, got_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      drive(1'b1, 1'(i), a, b);
      tick();
      exp_v = model(1'b1, 1'(i), a, b);
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_%0d a=%h b=%h got %h exp %h",
                 i, a, b, got_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 8'h40, 8'h41);
    tick();
    drive(1'b1, 1'b1, 8'h10, 8'h33);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (got_v !== 13'h0) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", got_v, 13'h0);
    end
    drive(1'b1, 1'b0, 8'hAA, 8'h11);
    tick();
    checks++;
    if (got_v !== 13'h0) begin
      errors++;
      $display("FAIL reset_ignores_in got %h exp %h", got_v, 13'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b1;
    sub = 1'b0;
    A = 8'h05;
    B = 8'h03;
    tick();
    exp_v = {4'b1000, 9'h008};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL post_reset_op got %h exp %h", got_v, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
